// File: rtl/hazard_pkg.sv
// hazard_pkg: shared latency constants and entry state type for the hazard scoreboard.
package hazard_pkg;
  localparam int CNT_W_MAX = 16;
  localparam logic [CNT_W_MAX-1:0] LAT_UNBOUNDED = '0;
  localparam logic [CNT_W_MAX-1:0] LAT_LOAD = CNT_W_MAX'(1);
  localparam logic [CNT_W_MAX-1:0] LAT_MULDIV = LAT_UNBOUNDED;
  localparam logic [4:0] OP_LOAD = 5'b01000;
  typedef struct packed {
    logic busy;
    logic unb;
    logic [CNT_W_MAX-1:0] cnt;
  } entry_t;
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: per-register pending state with a countdown for fixed latency and a writeback release for unbounded producers.
module hazard_sb_entry import hazard_pkg::*; (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 set_i,
  input  logic                 set_unb_i,
  input  logic [CNT_W_MAX-1:0] set_cnt_i,
  input  logic                 dec_i,
  input  logic                 wb_clr_i,
  output logic                 busy_o
);
  entry_t e_q, e_d;
  // A new producer overrides any same-cycle expiry or writeback.
  always_comb begin
    e_d = e_q;
    if (set_i) e_d = '{busy: 1'b1, unb: set_unb_i, cnt: set_unb_i ? LAT_UNBOUNDED : set_cnt_i};
    else if (e_q.busy && e_q.unb) e_d = wb_clr_i ? entry_t'(0) : e_q;
    else if (e_q.busy && dec_i) begin
      e_d.cnt = e_q.cnt - CNT_W_MAX'(1);
      e_d.busy = e_q.cnt != CNT_W_MAX'(1);
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) e_q <= '0;
    else e_q <= e_d;
  end
  assign busy_o = e_q.busy;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW/WAW interlock holding issue until sources and destination are no longer pending.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 4,
  parameter int NUM_SRC = 2,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     issue_valid,
  input  logic                     issue_rd_valid,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic [CNT_W-1:0]         issue_lat,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*REG_W-1:0] src_addr,
  input  logic                     flush,
  input  logic                     wb_valid,
  input  logic [REG_W-1:0]         wb_rd,
  output logic                     stall,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [31:0]              stall_count
);
  logic raw, waw, accept, zero_rd;
  logic [CNT_W_MAX-1:0] lat_ext;
  logic [31:0] stall_count_q, stall_count_d;
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) raw = raw | (src_valid[i] & busy_vec[src_addr[i*REG_W +: REG_W]]);
  end
  assign waw = issue_rd_valid & busy_vec[issue_rd];
  assign stall = issue_valid & ~flush & (raw | waw);
  assign zero_rd = (ZERO_HARDWIRED != 0) && (issue_rd == '0);
  assign accept = issue_valid & ~flush & ~stall & issue_rd_valid & ~zero_rd;
  assign lat_ext = CNT_W_MAX'(issue_lat);
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry u_entry (
      .clock     (clock),
      .reset_n   (reset_n),
      .set_i     (accept && issue_rd == REG_W'(r)),
      .set_unb_i (lat_ext == LAT_UNBOUNDED),
      .set_cnt_i (lat_ext),
      .dec_i     (1'b1),
      .wb_clr_i  (wb_valid && wb_rd == REG_W'(r)),
      .busy_o    (busy_vec[r])
    );
  end
  assign stall_count_d = (stall && stall_count_q != '1) ? stall_count_q + 32'd1 : stall_count_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_count_q <= '0;
    else stall_count_q <= stall_count_d;
  end
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random issue traffic checked against a remaining-cycles register model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;
  logic clock, reset_n, issue_valid, issue_rd_valid, flush, wb_valid, stall;
  logic [4:0] issue_rd, wb_rd;
  logic [3:0] issue_lat;
  logic [1:0] src_valid;
  logic [9:0] src_addr;
  logic [31:0] busy_vec, stall_count;
  int errors = 0, checks = 0;
  int rem [32];
  int unsigned exp_cnt = 0;

  hazard_scoreboard dut (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_rd_valid(issue_rd_valid),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_valid(src_valid), .src_addr(src_addr),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall), .busy_vec(busy_vec),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic rdv, input int rd, input int lat, input logic [1:0] sv,
                       input int sa0, input int sa1, input logic fl, input logic wbv, input int wbrd);
    issue_valid = iv;
    issue_rd_valid = rdv;
    issue_rd = 5'(rd);
    issue_lat = 4'(lat);
    src_valid = sv;
    src_addr = {5'(sa1), 5'(sa0)};
    flush = fl;
    wb_valid = wbv;
    wb_rd = 5'(wbrd);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) rem[r] = 0;
    exp_cnt = 0;
  endtask

  // rem[r]: 0 free, >0 cycles of pending left, -1 waiting for writeback
  task automatic step();
    logic raw, waw, es, acc;
    logic [31:0] ebv;
    int ird;
    @(negedge clock);
    raw = 1'b0;
    for (int i = 0; i < 2; i++) if (src_valid[i] && rem[int'(src_addr[i*5 +: 5])] != 0) raw = 1'b1;
    ird = int'(issue_rd);
    waw = issue_rd_valid && rem[ird] != 0;
    es = issue_valid && !flush && (raw || waw);
    for (int r = 0; r < 32; r++) ebv[r] = rem[r] != 0;
    chk("stall", 32'(stall), 32'(es));
    chk("busy_vec", busy_vec, ebv);
    chk("stall_count", stall_count, exp_cnt);
    acc = issue_valid && !flush && !es && issue_rd_valid && ird != 0;
    for (int r = 0; r < 32; r++) begin
      if (acc && r == ird) rem[r] = (issue_lat == 0) ? -1 : int'(issue_lat);
      else if (rem[r] > 0) rem[r]--;
      else if (rem[r] < 0 && wb_valid && int'(wb_rd) == r) rem[r] = 0;
    end
    if (es && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int q[$];
    int wr;
    logic wv;
    model_reset();
    reset_n = 1'b0;
    idle();
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy_vec", busy_vec, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
    @(posedge clock);
    #3;
    reset_n = 1'b1;

    // load-use: one bubble
    drive(1'b1, 1'b1, 5, int'(LAT_LOAD), 2'b00, 0, 0, 1'b0, 1'b0, 0);
    step();
    drive(1'b1, 1'b0, 0, 0, 2'b01, 5, 0, 1'b0, 1'b0, 0);
    step();
    step();
    chk("load_use_count", stall_count, 32'd1);

    // latency 3 producer, immediate consumer
    idle();
    step();
    drive(1'b1, 1'b1, 7, 3, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    step();
    drive(1'b1, 1'b0, 0, 0, 2'b10, 1, 7, 1'b0, 1'b0, 0);
    step();
    step();
    chk("r7_pending", 32'(busy_vec[7]), 32'd1);
    step();
    chk("r7_released", 32'(busy_vec[7]), 32'd0);
    step();
    chk("lat3_count", stall_count, 32'd4);

    // unbounded r9 released by writeback
    drive(1'b1, 1'b1, 9, int'(LAT_MULDIV), 2'b00, 0, 0, 1'b0, 1'b0, 0);
    step();
    drive(1'b1, 1'b0, 0, 0, 2'b01, 9, 0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 6; k++) step();
    drive(1'b1, 1'b0, 0, 0, 2'b01, 9, 0, 1'b0, 1'b1, 9);
    #1;
    chk("wb_cycle_stall", 32'(stall), 32'd1);
    step();
    drive(1'b1, 1'b0, 0, 0, 2'b01, 9, 0, 1'b0, 1'b0, 0);
    chk("r9_released", 32'(busy_vec[9]), 32'd0);
    step();

    // r0 never busy
    drive(1'b1, 1'b1, 0, 3, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    step();
    chk("r0_not_busy", busy_vec, 32'd0);
    drive(1'b1, 1'b0, 0, 0, 2'b11, 0, 0, 1'b0, 1'b0, 0);
    step();

    // WAW on pending unbounded r4, then flushed issues
    drive(1'b1, 1'b1, 4, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    step();
    drive(1'b1, 1'b1, 4, 2, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    step();
    drive(1'b1, 1'b1, 4, 2, 2'b00, 0, 0, 1'b1, 1'b0, 0);
    step();
    drive(1'b1, 1'b1, 10, 2, 2'b00, 0, 0, 1'b1, 1'b0, 0);
    step();
    chk("flush_no_entry", 32'(busy_vec[10]), 32'd0);

    // writeback to a counted entry is ignored
    drive(1'b1, 1'b1, 11, 5, 2'b00, 0, 0, 1'b0, 1'b1, 4);
    step();
    drive(1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b1, 11);
    step();
    chk("wb_counted_ignored", 32'(busy_vec[11]), 32'd1);
    idle();
    for (int k = 0; k < 5; k++) step();

    // asynchronous reset mid-countdown
    drive(1'b1, 1'b1, 3, 3, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    step();
    idle();
    step();
    drive(1'b1, 1'b0, 0, 0, 2'b01, 3, 0, 1'b0, 1'b0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_busy_vec", busy_vec, 32'd0);
    chk("arst_stall_count", stall_count, 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step();

    for (int n = 0; n < 400; n++) begin
      q.delete();
      for (int r = 0; r < 32; r++) if (rem[r] < 0) q.push_back(r);
      wv = 1'b0;
      wr = 0;
      if (q.size() != 0 && $urandom_range(0, 2) == 0) begin
        wv = 1'b1;
        wr = q[$urandom_range(0, q.size() - 1)];
      end else if ($urandom_range(0, 7) == 0) begin
        wv = 1'b1;
        wr = $urandom_range(0, 7);
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 5), 2'($urandom),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 9) == 0, wv, wr);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
